// File: rtl/monte_carlo_eval_if.sv
// Playout-engine handshake: the evaluator (master) requests one playout with a
// forced first move; the engine (slave) answers with a one-cycle ack strobe.
interface monte_carlo_eval_if #(
  parameter int BOARD_W = 80,
  parameter int SCORE_W = 16,
  parameter int MW      = 2
);
  logic               po_req;
  logic [BOARD_W-1:0] po_board;
  logic [MW-1:0]      po_first_move;
  logic               po_ack;
  logic [SCORE_W-1:0] po_score;
  logic               po_legal;

  modport master (
    output po_req, po_board, po_first_move,
    input  po_ack, po_score, po_legal
  );

  modport slave (
    input  po_req, po_board, po_first_move,
    output po_ack, po_score, po_legal
  );
endinterface

// File: rtl/monte_carlo_eval.sv
// Monte-Carlo move evaluator: runs `trials` playouts per candidate first move,
// accumulates saturating scores, then scans for the best legal move.
module monte_carlo_eval #(
  parameter int  NUM_MOVES = 4,
  parameter int  BOARD_W   = 80,
  parameter int  TRIALS_W  = 8,
  parameter int  SCORE_W   = 16,
  parameter int  ACC_W     = 24,
  localparam int MW        = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BOARD_W-1:0]  initial_board,
  input  logic [TRIALS_W-1:0] trials,
  monte_carlo_eval_if.master  po,
  output logic                busy,
  output logic                done,
  output logic [MW-1:0]       best_move,
  output logic [ACC_W-1:0]    best_score,
  output logic                no_move
);

  localparam int               SUM_W     = ((ACC_W > SCORE_W) ? ACC_W : SCORE_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
  localparam logic [MW-1:0]    LAST_MOVE = MW'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, NEXT, CMP, DONE} state_t;

  state_t r_state, w_state_next;

  logic [BOARD_W-1:0]  r_board;
  logic [TRIALS_W-1:0] r_trials;
  logic [TRIALS_W-1:0] r_trial;
  logic [MW-1:0]       r_move;
  logic [MW-1:0]       r_cmp_idx;
  logic                r_found;
  logic [ACC_W-1:0]    r_best_acc;
  logic [MW-1:0]       r_best_idx;
  logic [MW-1:0]       r_best_move;
  logic [ACC_W-1:0]    r_best_score;
  logic                r_no_move;

  logic                w_po_req, w_busy, w_done;
  logic                w_accept, w_ack_hit, w_more_trials;
  logic [TRIALS_W:0]   w_trial_inc;
  logic [ACC_W-1:0]    w_acc [NUM_MOVES];
  logic [NUM_MOVES-1:0] w_illegal;
  logic [ACC_W-1:0]    w_cmp_acc;
  logic                w_take;
  logic [MW-1:0]       w_best_idx_n;
  logic [ACC_W-1:0]    w_best_acc_n;

  assign w_accept      = (r_state == IDLE) && start;
  assign w_ack_hit     = (r_state == WAIT) && po.po_ack;
  assign w_trial_inc   = {1'b0, r_trial} + (TRIALS_W + 1)'(1);
  assign w_more_trials = (w_trial_inc < {1'b0, r_trials}) && !w_illegal[r_move];

  // An illegal verdict only counts on the first trial; later ones are scored normally.
  generate
    for (genvar gi = 0; gi < NUM_MOVES; gi++) begin : g_move
      logic [ACC_W-1:0] r_acc;
      logic             r_illegal;
      logic [SUM_W-1:0] w_sum;

      assign w_sum = SUM_W'(r_acc) + SUM_W'(po.po_score);

      always_ff @(posedge clk) begin
        if (rst || w_accept) begin
          r_acc     <= '0;
          r_illegal <= 1'b0;
        end else if (w_ack_hit && (r_move == MW'(gi))) begin
          if (!po.po_legal && (r_trial == '0))
            r_illegal <= 1'b1;
          else if (w_sum > SUM_W'(ACC_MAX))
            r_acc <= ACC_MAX;
          else
            r_acc <= w_sum[ACC_W-1:0];
        end
      end

      assign w_acc[gi]     = r_acc;
      assign w_illegal[gi] = r_illegal;
    end
  endgenerate

  assign w_cmp_acc    = w_acc[r_cmp_idx];
  assign w_take       = !w_illegal[r_cmp_idx] && (!r_found || (w_cmp_acc > r_best_acc));
  assign w_best_idx_n = w_take ? r_cmp_idx : r_best_idx;
  assign w_best_acc_n = w_take ? w_cmp_acc : r_best_acc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_po_req     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = (trials == '0) ? DONE : REQ;
      end
      REQ: begin
        w_po_req     = 1'b1;
        w_busy       = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        w_po_req = 1'b1;
        w_busy   = 1'b1;
        if (po.po_ack) w_state_next = NEXT;
      end
      NEXT: begin
        w_busy = 1'b1;
        if (!w_more_trials && (r_move == LAST_MOVE)) w_state_next = CMP;
        else                                         w_state_next = REQ;
      end
      CMP: begin
        w_busy = 1'b1;
        if (r_cmp_idx == LAST_MOVE) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_board      <= '0;
      r_trials     <= '0;
      r_trial      <= '0;
      r_move       <= '0;
      r_cmp_idx    <= '0;
      r_found      <= 1'b0;
      r_best_acc   <= '0;
      r_best_idx   <= '0;
      r_best_move  <= '0;
      r_best_score <= '0;
      r_no_move    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_board    <= initial_board;
            r_trials   <= trials;
            r_trial    <= '0;
            r_move     <= '0;
            r_cmp_idx  <= '0;
            r_found    <= 1'b0;
            r_best_acc <= '0;
            r_best_idx <= '0;
            if (trials == '0) begin
              r_best_move  <= '0;
              r_best_score <= '0;
              r_no_move    <= 1'b1;
            end
          end
        end
        NEXT: begin
          if (w_more_trials) begin
            r_trial <= r_trial + TRIALS_W'(1);
          end else begin
            r_trial <= '0;
            r_move  <= r_move + MW'(1);
          end
        end
        CMP: begin
          r_cmp_idx  <= r_cmp_idx + MW'(1);
          r_found    <= r_found || w_take;
          r_best_idx <= w_best_idx_n;
          r_best_acc <= w_best_acc_n;
          // Results are published on the last scan step so they are valid with done.
          if (r_cmp_idx == LAST_MOVE) begin
            r_best_move  <= w_best_idx_n;
            r_best_score <= w_best_acc_n;
            r_no_move    <= !(r_found || w_take);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = w_busy;
  assign done             = w_done;
  assign best_move        = r_best_move;
  assign best_score       = r_best_score;
  assign no_move          = r_no_move;
  assign po.po_req        = w_po_req;
  assign po.po_board      = r_board;
  assign po.po_first_move = r_move;

endmodule

// File: tb/tb_monte_carlo_eval.sv
// Bench for monte_carlo_eval: behavioural playout engine with random latency,
// plus a score/argmax reference model computed from per-move score tables.
`timescale 1ns/1ps
module tb_monte_carlo_eval;
  localparam int NM = 4, BW = 80, TW = 8, SW = 16, AW = 16, MW = 2;
  localparam int MAXT = 256;
  localparam longint AMAX = (longint'(1) << AW) - 1;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [BW-1:0] board_in = '0;
  logic [TW-1:0] trials_in = '0;
  logic          busy, done, no_move;
  logic [MW-1:0] best_move;
  logic [AW-1:0] best_score;

  monte_carlo_eval_if #(.BOARD_W(BW), .SCORE_W(SW), .MW(MW)) pif ();

  monte_carlo_eval #(.NUM_MOVES(NM), .BOARD_W(BW), .TRIALS_W(TW), .SCORE_W(SW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .initial_board(board_in), .trials(trials_in),
    .po(pif), .busy(busy), .done(done), .best_move(best_move),
    .best_score(best_score), .no_move(no_move)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [SW-1:0] score_tbl [NM][MAXT];
  bit            legal_tbl [NM][MAXT];
  int            req_mv [NM];
  int            req_total = 0, proto_err = 0;
  int            eng_min_lat = 0, eng_max_lat = 0;
  bit            eng_pending = 0, eng_abort = 0, inject_ack = 0, last_req = 0;
  logic [BW-1:0] exp_board = '0;
  int            cur_mv = 0, cur_tr = 0, wait_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Playout engine model, acting 2ns after each rising edge.
  initial begin
    pif.po_ack   = 1'b0;
    pif.po_score = '0;
    pif.po_legal = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (pif.po_ack && pif.po_req) proto_err++;
      pif.po_ack = 1'b0;
      if (eng_abort) begin
        eng_pending = 0;
        eng_abort   = 0;
      end
      if (inject_ack) begin
        pif.po_ack   = 1'b1;
        pif.po_legal = 1'b1;
        pif.po_score = 16'h1234;
        inject_ack   = 0;
      end else if (pif.po_req && !last_req) begin
        req_total++;
        cur_mv = int'(pif.po_first_move);
        cur_tr = (req_mv[cur_mv] < MAXT) ? req_mv[cur_mv] : MAXT - 1;
        req_mv[cur_mv]++;
        if (pif.po_board !== exp_board) proto_err++;
        wait_cnt    = $urandom_range(eng_max_lat, eng_min_lat);
        eng_pending = 1;
      end else if (eng_pending) begin
        if (pif.po_board !== exp_board || !pif.po_req) proto_err++;
        if (wait_cnt == 0) begin
          pif.po_ack   = 1'b1;
          pif.po_score = score_tbl[cur_mv][cur_tr];
          pif.po_legal = legal_tbl[cur_mv][cur_tr];
          eng_pending  = 0;
        end else begin
          wait_cnt--;
        end
      end
      last_req = pif.po_req;
    end
  end

  task automatic fill_move(input int m, input int n, input logic [SW-1:0] s0,
                           input logic [SW-1:0] s1, input bit legal0);
    for (int t = 0; t < MAXT; t++) begin
      score_tbl[m][t] = (t == 0) ? s0 : s1;
      legal_tbl[m][t] = (t == 0) ? legal0 : 1'b1;
    end
    if (n < 0) score_tbl[m][0] = s0;
  endtask

  task automatic new_board();
    logic [95:0] rb;
    rb = {$urandom(), $urandom(), $urandom()};
    exp_board = rb[BW-1:0];
    for (int m = 0; m < NM; m++) req_mv[m] = 0;
    req_total = 0;
    proto_err = 0;
  endtask

  task automatic run_eval(input string tag, input int ntr, input bit poke_busy);
    int     exp_rq [NM];
    int     exp_reqs, exp_move, cyc, busy_bad;
    longint s, exp_score;
    bit     found;
    found = 0; exp_move = 0; exp_score = 0; exp_reqs = 0;
    for (int m = 0; m < NM; m++) begin
      if (ntr == 0) exp_rq[m] = 0;
      else if (!legal_tbl[m][0]) exp_rq[m] = 1;
      else begin
        exp_rq[m] = ntr;
        s = 0;
        for (int t = 0; t < ntr; t++) s += longint'(score_tbl[m][t]);
        if (s > AMAX) s = AMAX;
        if (!found || s > exp_score) begin
          found = 1; exp_move = m; exp_score = s;
        end
      end
      exp_reqs += exp_rq[m];
    end

    new_board();
    board_in  = exp_board;
    trials_in = TW'(ntr);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    board_in  = ~exp_board;
    trials_in = ~TW'(ntr);
    cyc = 0; busy_bad = 0;
    while (!done && cyc < 6000) begin
      if (!busy) busy_bad++;
      start = (poke_busy && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, "_busy_gaps"}, 64'(busy_bad), 64'(0));
    chk({tag, "_best_move"}, 64'(best_move), 64'(exp_move));
    chk({tag, "_best_score"}, 64'(best_score), 64'(exp_score));
    chk({tag, "_no_move"}, 64'(no_move), 64'(!found));
    chk({tag, "_req_total"}, 64'(req_total), 64'(exp_reqs));
    for (int m = 0; m < NM; m++) chk({tag, "_req_mv"}, 64'(req_mv[m]), 64'(exp_rq[m]));
    chk({tag, "_protocol"}, 64'(proto_err), 64'(0));
    if (ntr == 0) chk({tag, "_latency"}, 64'(cyc <= 2), 64'(1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_hold_score"}, 64'(best_score), 64'(exp_score));
    $display("run %s trials=%0d reqs=%0d best_move=%0d best_score=0x%0h no_move=%0b cycles=%0d",
             tag, ntr, req_total, best_move, best_score, no_move, cyc);
  endtask

  initial begin
    int cyc, bad, ntr;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_po_req", 64'(pif.po_req), 64'(0));
    chk("reset_best_move", 64'(best_move), 64'(0));
    chk("reset_best_score", 64'(best_score), 64'(0));
    chk("reset_no_move", 64'(no_move), 64'(0));

    // Stray ack while idle must have no effect.
    inject_ack = 1;
    repeat (2) @(posedge clk); #1;
    chk("idle_ack_busy", 64'(busy), 64'(0));

    eng_min_lat = 0; eng_max_lat = 3;
    fill_move(0, 2, 16'd10, 16'd20, 1'b1);
    fill_move(1, 2, 16'd50, 16'd5, 1'b1);
    fill_move(2, 2, 16'd30, 16'd30, 1'b1);
    fill_move(3, 2, 16'd1, 16'd1, 1'b1);
    run_eval("basic", 2, 1'b0);

    // Reset during WAIT, then a late ack.
    eng_min_lat = 30; eng_max_lat = 30;
    new_board();
    board_in = exp_board; trials_in = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!pif.po_req && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rst_req_seen", 64'(pif.po_req), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1; eng_abort = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_po_req", 64'(pif.po_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_best_move", 64'(best_move), 64'(0));
    chk("rst_best_score", 64'(best_score), 64'(0));
    chk("rst_no_move", 64'(no_move), 64'(0));
    inject_ack = 1; bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || pif.po_req || busy) bad++;
    end
    chk("rst_late_ack_quiet", 64'(bad), 64'(0));
    $display("reset_mid_wait quiet_violations=%0d", bad);

    eng_min_lat = 0; eng_max_lat = 2;
    run_eval("after_reset", 2, 1'b0);

    fill_move(0, 3, 16'd9, 16'd9, 1'b0);
    fill_move(1, 3, 16'd9, 16'd9, 1'b0);
    fill_move(2, 3, 16'd7, 16'd7, 1'b1);
    fill_move(3, 3, 16'd7, 16'd7, 1'b1);
    run_eval("partial_illegal", 3, 1'b0);

    for (int m = 0; m < NM; m++) fill_move(m, 5, 16'd100, 16'd100, 1'b0);
    run_eval("all_illegal", 5, 1'b0);

    run_eval("zero_trials", 0, 1'b0);

    eng_min_lat = 0; eng_max_lat = 0;
    for (int m = 0; m < NM; m++) fill_move(m, 255, 16'hFFFF, 16'hFFFF, 1'b1);
    run_eval("saturate", 255, 1'b0);

    eng_min_lat = 0; eng_max_lat = 3;
    for (int r = 0; r < 8; r++) begin
      for (int m = 0; m < NM; m++)
        for (int t = 0; t < MAXT; t++) begin
          score_tbl[m][t] = (r < 2) ? 16'($urandom_range(65535, 30000)) : 16'($urandom_range(200, 0));
          legal_tbl[m][t] = ($urandom_range(3, 0) != 0);
        end
      ntr = $urandom_range(6, 1);
      run_eval("random", ntr, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
